// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared types, widths and forwarding-select helper for the execute stage
package exe_stage_pkg;
  localparam int WORD_LEN = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int SHAMT_LEN = $clog2(WORD_LEN);
  typedef enum logic [3:0] {
    EXE_NOP, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR, EXE_SLL, EXE_SRL, EXE_SLT, EXE_MUL
  } execmd_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} exe_state_t;
  typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_t;
  // r0 is hardwired zero, so a producer targeting it never forwards; MEM is younger and wins
  function automatic fwd_sel_t fwd_sel(
    input logic [REG_FILE_ADDR_LEN-1:0] src, mem_dest,
    input logic mem_en,
    input logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    input logic wb_en
  );
    return (mem_en && mem_dest == src && mem_dest != '0) ? FWD_MEM :
           (wb_en && wb_dest == src && wb_dest != '0) ? FWD_WB : FWD_NONE;
  endfunction
endpackage

// File: rtl/exe_stage_iter_multiplier.sv
// iter_multiplier: shift-add multiplier, one multiplier bit per busy cycle, low WORD_LEN bits kept
module iter_multiplier
  import exe_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 busy,
  input  logic [WORD_LEN-1:0]  a,
  input  logic [WORD_LEN-1:0]  b,
  output logic                 done,
  output logic [WORD_LEN-1:0]  product,
  output logic [SHAMT_LEN-1:0] cnt
);
  logic [WORD_LEN-1:0] mcand, mplier;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      product <= '0;
      cnt <= '0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      product <= '0;
      cnt <= '0;
    end else if (busy) begin
      product <= product + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
  assign done = busy && cnt == SHAMT_LEN'(WORD_LEN - 1);
endmodule

// File: rtl/exe_stage.sv
// exe_stage: operand forwarding, single-cycle ALU, iterative multiply control and EXE/MEM register
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  execmd_t                      exe_cmd_in,
  input  logic [WORD_LEN-1:0]          val1_in,
  input  logic [WORD_LEN-1:0]          val2_in,
  input  logic                         val2_is_reg,
  input  logic [WORD_LEN-1:0]          st_value_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
  input  logic                         wb_en_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] mem_fwd_dest,
  input  logic                         mem_fwd_wb_en,
  input  logic [WORD_LEN-1:0]          mem_fwd_val,
  input  logic [REG_FILE_ADDR_LEN-1:0] wb_fwd_dest,
  input  logic                         wb_fwd_wb_en,
  input  logic [WORD_LEN-1:0]          wb_fwd_val,
  output logic                         exe_stall,
  output logic [WORD_LEN-1:0]          alu_result,
  output logic [WORD_LEN-1:0]          st_value,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic                         wb_en,
  output logic                         mem_r_en,
  output logic                         mem_w_en
);
  exe_state_t state;
  fwd_sel_t sel1, sel2, sels;
  logic [WORD_LEN-1:0] op1, op2, st_fwd, alu_res, product;
  logic [SHAMT_LEN-1:0] cnt;
  logic is_mul, mul_start, mul_busy, mul_done;
  assign sel1 = fwd_sel(src1_in, mem_fwd_dest, mem_fwd_wb_en, wb_fwd_dest, wb_fwd_wb_en);
  assign sels = fwd_sel(src2_in, mem_fwd_dest, mem_fwd_wb_en, wb_fwd_dest, wb_fwd_wb_en);
  assign sel2 = val2_is_reg ? sels : FWD_NONE;
  assign op1 = sel1 == FWD_MEM ? mem_fwd_val : sel1 == FWD_WB ? wb_fwd_val : val1_in;
  assign op2 = sel2 == FWD_MEM ? mem_fwd_val : sel2 == FWD_WB ? wb_fwd_val : val2_in;
  assign st_fwd = sels == FWD_MEM ? mem_fwd_val : sels == FWD_WB ? wb_fwd_val : st_value_in;
  always_comb begin
    alu_res = '0;
    case (exe_cmd_in)
      EXE_ADD: alu_res = op1 + op2;
      EXE_SUB: alu_res = op1 - op2;
      EXE_AND: alu_res = op1 & op2;
      EXE_OR:  alu_res = op1 | op2;
      EXE_XOR: alu_res = op1 ^ op2;
      EXE_SLL: alu_res = op1 << op2[SHAMT_LEN-1:0];
      EXE_SRL: alu_res = op1 >> op2[SHAMT_LEN-1:0];
      EXE_SLT: alu_res = WORD_LEN'($signed(op1) < $signed(op2));
      default: alu_res = '0;
    endcase
  end
  assign is_mul = exe_cmd_in == EXE_MUL;
  assign mul_start = state == IDLE && is_mul && !flush;
  assign mul_busy = state == BUSY && !flush;
  // DONE releases the stall so upstream advances on the same edge the product is registered
  assign exe_stall = !flush && (state == BUSY || (state == IDLE && is_mul));
  iter_multiplier u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .busy    (mul_busy),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (product),
    .cnt     (cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= flush ? IDLE :
                  state == IDLE ? (is_mul ? BUSY : IDLE) :
                  state == BUSY ? (mul_done ? DONE : BUSY) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst || exe_stall || flush) begin
      alu_result <= '0;
      st_value <= '0;
      dest <= '0;
      wb_en <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
    end else begin
      alu_result <= state == DONE ? product : alu_res;
      st_value <= st_fwd;
      dest <= dest_in;
      wb_en <= wb_en_in && exe_cmd_in != EXE_NOP;
      mem_r_en <= mem_r_en_in;
      mem_w_en <= mem_w_en_in;
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vector table plus multiply, flush and async-reset sequences
module tb_exe_stage;
  import exe_stage_pkg::*;
  logic clk = 0, rst = 1, flush = 0;
  execmd_t exe_cmd_in = EXE_NOP;
  logic [31:0] val1_in = 0, val2_in = 0, st_value_in = 0, mem_fwd_val = 0, wb_fwd_val = 0;
  logic val2_is_reg = 0, wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, mem_fwd_wb_en = 0, wb_fwd_wb_en = 0;
  logic [4:0] src1_in = 0, src2_in = 0, dest_in = 0, mem_fwd_dest = 0, wb_fwd_dest = 0;
  logic exe_stall, wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_value;
  logic [4:0] dest;
  int checks = 0, errors = 0;
  exe_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .exe_cmd_in(exe_cmd_in),
    .val1_in(val1_in), .val2_in(val2_in), .val2_is_reg(val2_is_reg), .st_value_in(st_value_in),
    .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .mem_fwd_dest(mem_fwd_dest), .mem_fwd_wb_en(mem_fwd_wb_en), .mem_fwd_val(mem_fwd_val),
    .wb_fwd_dest(wb_fwd_dest), .wb_fwd_wb_en(wb_fwd_wb_en), .wb_fwd_val(wb_fwd_val),
    .exe_stall(exe_stall), .alu_result(alu_result), .st_value(st_value), .dest(dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en)
  );
  always #5 clk = ~clk;
  typedef struct {
    execmd_t cmd;
    logic [31:0] v1, v2, v2reg, st, s1, s2, d, wb, mr, mw, md, me, mv, wd, we, wv, res, exp_st, exp_wb;
  } vec_t;
  localparam int NV = 16;
  vec_t vecs [NV];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    exe_cmd_in = v.cmd; val1_in = v.v1; val2_in = v.v2; val2_is_reg = v.v2reg[0];
    st_value_in = v.st; src1_in = v.s1[4:0]; src2_in = v.s2[4:0]; dest_in = v.d[4:0];
    wb_en_in = v.wb[0]; mem_r_en_in = v.mr[0]; mem_w_en_in = v.mw[0];
    mem_fwd_dest = v.md[4:0]; mem_fwd_wb_en = v.me[0]; mem_fwd_val = v.mv;
    wb_fwd_dest = v.wd[4:0]; wb_fwd_wb_en = v.we[0]; wb_fwd_val = v.wv;
  endtask
  task automatic op(input execmd_t c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    drive('{c, a, b, 0, 0, 0, 0, 32'(d), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int n;
    //           cmd      v1            v2            reg st  s1 s2 d  wb mr mw md me mv          wd we wv          res           st    wb
    vecs[0]  = '{EXE_ADD, 5,            10,           0, 9,  3, 4, 1, 1, 0, 0, 3, 1, 100,        3, 1, 7,          110,          9,    1};
    vecs[1]  = '{EXE_SUB, 0,            1,            1, 0,  0, 0, 2, 1, 0, 0, 0, 0, 0,          0, 0, 0,          32'hFFFFFFFF, 0,    1};
    vecs[2]  = '{EXE_SLT, 32'hFFFFFFFF, 1,            1, 0,  0, 0, 3, 1, 0, 0, 0, 0, 0,          0, 0, 0,          1,            0,    1};
    vecs[3]  = '{EXE_SRL, 32'h80000000, 31,           0, 0,  0, 0, 4, 1, 0, 0, 0, 0, 0,          0, 0, 0,          1,            0,    1};
    vecs[4]  = '{EXE_ADD, 2,            3,            1, 7,  0, 0, 5, 1, 1, 0, 0, 1, 32'hDEAD,   0, 1, 32'hDEAD,   5,            7,    1};
    vecs[5]  = '{EXE_ADD, 1,            4,            0, 0,  0, 6, 6, 1, 0, 1, 6, 1, 1000,       0, 0, 0,          5,            1000, 1};
    vecs[6]  = '{EXE_ADD, 1,            4,            1, 0,  0, 6, 7, 1, 0, 0, 6, 1, 1000,       0, 0, 0,          1001,         1000, 1};
    vecs[7]  = '{EXE_ADD, 0,            1,            1, 0,  7, 0, 8, 1, 0, 0, 0, 0, 0,          7, 1, 50,         51,           0,    1};
    vecs[8]  = '{EXE_AND, 32'hF0F0,     32'hFF00,     0, 0,  0, 0, 9, 1, 0, 0, 0, 0, 0,          0, 0, 0,          32'hF000,     0,    1};
    vecs[9]  = '{EXE_OR,  32'hF0F0,     32'hFF00,     0, 0,  0, 0, 10, 1, 0, 0, 0, 0, 0,         0, 0, 0,          32'hFFF0,     0,    1};
    vecs[10] = '{EXE_XOR, 32'hF0F0,     32'hFF00,     0, 0,  0, 0, 11, 1, 0, 0, 0, 0, 0,         0, 0, 0,          32'h0FF0,     0,    1};
    vecs[11] = '{EXE_SLL, 1,            33,           0, 0,  0, 0, 12, 1, 0, 0, 0, 0, 0,         0, 0, 0,          2,            0,    1};
    vecs[12] = '{EXE_NOP, 5,            6,            0, 0,  0, 0, 13, 1, 0, 0, 0, 0, 0,         0, 0, 0,          0,            0,    0};
    vecs[13] = '{EXE_SLT, 1,            32'hFFFFFFFF, 1, 0,  0, 0, 14, 1, 0, 0, 0, 0, 0,         0, 0, 0,          0,            0,    1};
    vecs[14] = '{EXE_ADD, 0,            0,            0, 0,  3, 0, 15, 1, 0, 0, 3, 0, 100,       3, 1, 7,          7,            0,    1};
    vecs[15] = '{EXE_ADD, 10,           1,            1, 0,  0, 5, 16, 1, 0, 0, 5, 1, 20,        5, 1, 30,         30,           20,   1};
    #1;
    chk("reset alu_result", alu_result, 0);
    chk("reset wb_en", 32'(wb_en), 0);
    chk("reset stall", 32'(exe_stall), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), 32'(exe_stall), 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d result", i), alu_result, vecs[i].res);
      chk($sformatf("v%0d st_value", i), st_value, vecs[i].exp_st);
      chk($sformatf("v%0d wb_en", i), 32'(wb_en), vecs[i].exp_wb);
      chk($sformatf("v%0d dest", i), 32'(dest), vecs[i].d);
      chk($sformatf("v%0d mem_r_en", i), 32'(mem_r_en), vecs[i].mr);
      chk($sformatf("v%0d mem_w_en", i), 32'(mem_w_en), vecs[i].mw);
    end
    // multiply: op1 arrives via MEM forwarding, which then changes while busy
    drive('{EXE_MUL, 0, 5, 1, 0, 1, 0, 9, 1, 0, 0, 1, 1, 32'h00010003, 0, 0, 0, 0, 0, 0});
    #1;
    n = 0;
    while (exe_stall && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) mem_fwd_val = 32'hFFFF;
      if (n == 10) chk("mul busy wb_en", 32'(wb_en), 0);
    end
    chk("mul stall cycles", n, 33);
    @(posedge clk);
    #1;
    chk("mul result", alu_result, 32'h0005000F);
    chk("mul wb_en", 32'(wb_en), 1);
    chk("mul dest", 32'(dest), 9);
    op(EXE_NOP, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("after mul wb_en", 32'(wb_en), 0);
    // flush during BUSY
    op(EXE_MUL, 7, 3, 4);
    repeat (11) @(posedge clk);
    #1;
    chk("busy stall", 32'(exe_stall), 1);
    flush = 1;
    #1;
    chk("flush stall", 32'(exe_stall), 0);
    @(posedge clk);
    #1;
    chk("flush wb_en", 32'(wb_en), 0);
    chk("flush result", alu_result, 0);
    flush = 0;
    op(EXE_ADD, 2, 3, 3);
    #1;
    chk("post-flush stall", 32'(exe_stall), 0);
    @(posedge clk);
    #1;
    chk("post-flush result", alu_result, 5);
    chk("post-flush wb_en", 32'(wb_en), 1);
    // flush with MUL in IDLE must not start it
    op(EXE_MUL, 4, 4, 5);
    flush = 1;
    #1;
    chk("idle flush stall", 32'(exe_stall), 0);
    @(posedge clk);
    #1;
    chk("idle flush wb_en", 32'(wb_en), 0);
    flush = 0;
    op(EXE_ADD, 4, 4, 5);
    #1;
    chk("no mul started stall", 32'(exe_stall), 0);
    @(posedge clk);
    #1;
    chk("no mul started result", alu_result, 8);
    // asynchronous reset clears outputs between edges
    op(EXE_ADD, 9, 1, 2);
    @(posedge clk);
    #1;
    chk("pre-reset result", alu_result, 10);
    #2 rst = 1;
    #1;
    chk("async rst result", alu_result, 0);
    chk("async rst wb_en", 32'(wb_en), 0);
    chk("async rst dest", 32'(dest), 0);
    @(negedge clk);
    rst = 0;
    // asynchronous reset mid-multiply returns the FSM to IDLE
    op(EXE_MUL, 3, 3, 6);
    repeat (6) @(posedge clk);
    #1;
    op(EXE_ADD, 20, 22, 7);
    #1;
    chk("mid-mul stall", 32'(exe_stall), 1);
    #1 rst = 1;
    #1;
    chk("mid-mul rst stall", 32'(exe_stall), 0);
    chk("mid-mul rst wb_en", 32'(wb_en), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("after rst result", alu_result, 42);
    chk("after rst wb_en", 32'(wb_en), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
